frame_sequencer: RTL and testbench

Sequences one image frame from the UART receiver into the `detect_face` HLS core, and holds off the laptop until the results have gone back. It sits between `uart_rcvr` and `detect_face_wrapper` in `top`. It:
- buffers each received pixel in a one-entry holding register and forwards it with the core's start/ready handshake;
- counts pixels and detects the terminal core result;
- drives `uart_rts` flow control;
- aborts stalled frames with a watchdog;
- exposes `frame_active` for cycle-count timing.

---
 rtl/frame_sequencer_if.sv | 39 +++
 rtl/frame_sequencer.sv | 157 +++++++++++++++
 tb/tb_frame_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : frame_sequencer_if                                        |
// | Desc     : UART-receiver / HLS-core / result-sender signal bundle    |
// |            for frame_sequencer.                                      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface frame_sequencer_if;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic [7:0]  core_pixel;
    logic        core_start;
    logic        core_ready;
    logic        core_done;
    logic [7:0]  core_return;
    logic        core_flush;
    logic        tx_done;
    logic        fpga_can_receive;
    logic        frame_active;
    logic        frame_done;
    logic        frame_has_face;
    logic [31:0] pixel_count;
    logic [1:0]  err;

    // Sequencer side
    modport master (
        input  rx_data, rx_rdy, core_ready, core_done, core_return, tx_done,
        output core_pixel, core_start, core_flush, fpga_can_receive,
               frame_active, frame_done, frame_has_face, pixel_count, err
    );

    // Surrounding system side (receiver, core, sender)
    modport slave (
        output rx_data, rx_rdy, core_ready, core_done, core_return, tx_done,
        input  core_pixel, core_start, core_flush, fpga_can_receive,
               frame_active, frame_done, frame_has_face, pixel_count, err
    );
endinterface
`default_nettype wire

// File: rtl/frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : frame_sequencer                                           |
// | Desc     : Feeds one frame of UART pixels into the detect_face core  |
// |            through a one-entry holding register, tracks the result,  |
// |            drives RTS flow control and aborts stalled frames.        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module frame_sequencer #(
    parameter int FRAME_PIXELS = 76800,
    parameter int BYTE_TIMEOUT = 1_000_000
) (
    input  logic             clock,
    input  logic             reset,
    frame_sequencer_if.master bus
);
    localparam int              c_WD_W   = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [c_WD_W-1:0] c_WD_MAX = c_WD_W'(BYTE_TIMEOUT);
    localparam logic [c_WD_W-1:0] c_WD_ONE = c_WD_W'(1);
    localparam logic [31:0]     c_FRAME  = 32'(FRAME_PIXELS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    state_t              r_state;
    logic [7:0]          r_hold_data;
    logic                r_hold_vld;
    logic                r_core_flush;
    logic                r_fpga_can_receive;
    logic                r_frame_active;
    logic                r_frame_done;
    logic                r_frame_has_face;
    logic [31:0]         r_pixel_count;
    logic [1:0]          r_err;
    logic [c_WD_W-1:0]   r_wdog;

    logic        w_consume;
    logic        w_terminal;
    logic [31:0] w_count_next;
    logic        w_last;

    assign w_consume    = r_hold_vld & bus.core_ready;
    assign w_terminal   = bus.core_done &
                          ((bus.core_return == 8'h01) | (bus.core_return == 8'hFF));
    assign w_count_next = r_pixel_count + 32'd1;
    assign w_last       = w_consume & (w_count_next == c_FRAME);

    // Frame state machine, holding register, watchdog and all registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state            <= S_IDLE;
            r_hold_data        <= 8'h00;
            r_hold_vld         <= 1'b0;
            r_core_flush       <= 1'b0;
            r_fpga_can_receive <= 1'b1;
            r_frame_active     <= 1'b0;
            r_frame_done       <= 1'b0;
            r_frame_has_face   <= 1'b0;
            r_pixel_count      <= 32'd0;
            r_err              <= 2'b00;
            r_wdog             <= '0;
        end else begin
            r_frame_done <= 1'b0;
            r_core_flush <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_fpga_can_receive <= 1'b1;
                    r_pixel_count      <= 32'd0;
                    r_wdog             <= '0;
                    if (bus.rx_rdy) begin
                        r_hold_data    <= bus.rx_data;
                        r_hold_vld     <= 1'b1;
                        r_frame_active <= 1'b1;
                        r_state        <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_terminal) begin
                        // Early finish: the core has its answer, anything held is stale
                        r_state            <= S_REPORT;
                        r_hold_vld         <= 1'b0;
                        r_frame_done       <= 1'b1;
                        r_frame_has_face   <= (bus.core_return == 8'h01);
                        r_fpga_can_receive <= 1'b0;
                        if (w_consume) r_pixel_count <= w_count_next;
                        if (bus.rx_rdy) r_err[0] <= 1'b1;
                    end else if (!bus.rx_rdy && (r_wdog == c_WD_MAX)) begin
                        // Sender went quiet mid-frame: abandon it and flush the core
                        r_err[1]       <= 1'b1;
                        r_core_flush   <= 1'b1;
                        r_hold_vld     <= 1'b0;
                        r_pixel_count  <= 32'd0;
                        r_frame_active <= 1'b0;
                        r_wdog         <= '0;
                        r_state        <= S_IDLE;
                    end else begin
                        r_wdog <= bus.rx_rdy ? '0 : (r_wdog + c_WD_ONE);
                        if (w_consume) r_pixel_count <= w_count_next;
                        if (w_last) begin
                            // Frame fully delivered; a byte arriving now belongs to no frame
                            r_state            <= S_DRAIN;
                            r_fpga_can_receive <= 1'b0;
                            r_hold_vld         <= 1'b0;
                            if (bus.rx_rdy) r_err[0] <= 1'b1;
                        end else if (bus.rx_rdy) begin
                            if (!r_hold_vld || w_consume) begin
                                r_hold_data <= bus.rx_data;
                                r_hold_vld  <= 1'b1;
                            end else begin
                                r_err[0] <= 1'b1;
                            end
                        end else if (w_consume) begin
                            r_hold_vld <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    r_fpga_can_receive <= 1'b0;
                    r_hold_vld         <= 1'b0;
                    if (bus.rx_rdy) r_err[0] <= 1'b1;
                    if (w_terminal) begin
                        r_state          <= S_REPORT;
                        r_frame_done     <= 1'b1;
                        r_frame_has_face <= (bus.core_return == 8'h01);
                    end
                end
                S_REPORT: begin
                    if (bus.rx_rdy) r_err[0] <= 1'b1;
                    if (bus.tx_done) begin
                        r_state            <= S_IDLE;
                        r_fpga_can_receive <= 1'b1;
                        r_frame_active     <= 1'b0;
                        r_pixel_count      <= 32'd0;
                    end else begin
                        r_fpga_can_receive <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.core_pixel       = r_hold_data;
    assign bus.core_start       = r_hold_vld;
    assign bus.core_flush       = r_core_flush;
    assign bus.fpga_can_receive = r_fpga_can_receive;
    assign bus.frame_active     = r_frame_active;
    assign bus.frame_done       = r_frame_done;
    assign bus.frame_has_face   = r_frame_has_face;
    assign bus.pixel_count      = r_pixel_count;
    assign bus.err              = r_err;
endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_frame_sequencer                                        |
// | Desc     : Directed self-checking bench for frame_sequencer with     |
// |            FRAME_PIXELS = 4 and BYTE_TIMEOUT = 16.                    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_frame_sequencer;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    frame_sequencer_if bus();

    frame_sequencer #(.FRAME_PIXELS(4), .BYTE_TIMEOUT(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        bus.rx_data = d;
        bus.rx_rdy  = 1'b1;
        tick();
        bus.rx_rdy  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic finish_frame(input logic [7:0] ret);
        bus.core_return = ret;
        bus.core_done   = 1'b1;
        tick();
        bus.core_done   = 1'b0;
        tick();
        bus.tx_done     = 1'b1;
        tick();
        bus.tx_done     = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.core_start !== 1'b0) begin errors++; $display("FAIL rst_core_start got %0b want 0", bus.core_start); end
        checks++; if (bus.core_pixel !== 8'h00) begin errors++; $display("FAIL rst_core_pixel got %h want 00", bus.core_pixel); end
        checks++; if (bus.fpga_can_receive !== 1'b1) begin errors++; $display("FAIL rst_rts got %0b want 1", bus.fpga_can_receive); end
        checks++; if (bus.frame_active !== 1'b0) begin errors++; $display("FAIL rst_frame_active got %0b want 0", bus.frame_active); end
        checks++; if (bus.pixel_count !== 32'd0) begin errors++; $display("FAIL rst_pixel_count got %0d want 0", bus.pixel_count); end
        checks++; if (bus.err !== 2'b00) begin errors++; $display("FAIL rst_err got %b want 00", bus.err); end
        checks++; if (bus.core_flush !== 1'b0) begin errors++; $display("FAIL rst_flush got %0b want 0", bus.core_flush); end
        checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got %0b want 0", bus.frame_done); end
    endtask

    task automatic test_normal();
        logic [7:0] d;
        bus.core_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = 8'(8'h10 + i);
            send_byte(d);
            checks++; if (bus.core_start !== 1'b1) begin errors++; $display("FAIL norm_start[%0d] got %0b want 1", i, bus.core_start); end
            checks++; if (bus.core_pixel !== d) begin errors++; $display("FAIL norm_pixel[%0d] got %h want %h", i, bus.core_pixel, d); end
            checks++; if (bus.pixel_count !== 32'(i)) begin errors++; $display("FAIL norm_count_pre[%0d] got %0d want %0d", i, bus.pixel_count, i); end
            checks++; if (bus.fpga_can_receive !== 1'b1) begin errors++; $display("FAIL norm_rts_stream[%0d] got %0b want 1", i, bus.fpga_can_receive); end
            tick();
            checks++; if (bus.pixel_count !== 32'(i + 1)) begin errors++; $display("FAIL norm_count_post[%0d] got %0d want %0d", i, bus.pixel_count, i + 1); end
            checks++; if (bus.core_start !== 1'b0) begin errors++; $display("FAIL norm_start_drop[%0d] got %0b want 0", i, bus.core_start); end
        end
        checks++; if (bus.fpga_can_receive !== 1'b0) begin errors++; $display("FAIL norm_rts_drain got %0b want 0", bus.fpga_can_receive); end
        checks++; if (bus.frame_active !== 1'b1) begin errors++; $display("FAIL norm_active got %0b want 1", bus.frame_active); end
        bus.core_return = 8'h01;
        bus.core_done   = 1'b1;
        tick();
        bus.core_done   = 1'b0;
        checks++; if (bus.frame_done !== 1'b1) begin errors++; $display("FAIL norm_frame_done got %0b want 1", bus.frame_done); end
        checks++; if (bus.frame_has_face !== 1'b1) begin errors++; $display("FAIL norm_has_face got %0b want 1", bus.frame_has_face); end
        tick();
        checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL norm_done_pulse got %0b want 0", bus.frame_done); end
        checks++; if (bus.fpga_can_receive !== 1'b0) begin errors++; $display("FAIL norm_rts_report got %0b want 0", bus.fpga_can_receive); end
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        checks++; if (bus.fpga_can_receive !== 1'b1) begin errors++; $display("FAIL norm_rts_idle got %0b want 1", bus.fpga_can_receive); end
        checks++; if (bus.frame_active !== 1'b0) begin errors++; $display("FAIL norm_active_end got %0b want 0", bus.frame_active); end
        checks++; if (bus.pixel_count !== 32'd0) begin errors++; $display("FAIL norm_count_end got %0d want 0", bus.pixel_count); end
        checks++; if (bus.err !== 2'b00) begin errors++; $display("FAIL norm_err got %b want 00", bus.err); end
    endtask

    task automatic test_back_pressure();
        logic [7:0] d;
        bus.core_ready = 1'b0;
        send_byte(8'h20);
        tick();
        send_byte(8'h21);
        checks++; if (bus.err !== 2'b01) begin errors++; $display("FAIL bp_overrun got %b want 01", bus.err); end
        checks++; if (bus.core_pixel !== 8'h20) begin errors++; $display("FAIL bp_pixel_held got %h want 20", bus.core_pixel); end
        checks++; if (bus.core_start !== 1'b1) begin errors++; $display("FAIL bp_start_held got %0b want 1", bus.core_start); end
        tick();
        bus.core_ready = 1'b1;
        tick();
        checks++; if (bus.pixel_count !== 32'd1) begin errors++; $display("FAIL bp_count got %0d want 1", bus.pixel_count); end
        checks++; if (bus.core_start !== 1'b0) begin errors++; $display("FAIL bp_dropped_presented got %0b want 0", bus.core_start); end
        for (int i = 0; i < 3; i++) begin
            d = 8'(8'h22 + i);
            send_byte(d);
            checks++; if (bus.core_pixel !== d) begin errors++; $display("FAIL bp_pixel[%0d] got %h want %h", i, bus.core_pixel, d); end
            tick();
        end
        checks++; if (bus.pixel_count !== 32'd4) begin errors++; $display("FAIL bp_count_end got %0d want 4", bus.pixel_count); end
        finish_frame(8'h01);
    endtask

    task automatic test_same_cycle();
        do_reset();
        bus.core_ready = 1'b1;
        send_byte(8'h30);
        send_byte(8'h31);
        checks++; if (bus.err !== 2'b00) begin errors++; $display("FAIL sc_err got %b want 00", bus.err); end
        checks++; if (bus.core_pixel !== 8'h31) begin errors++; $display("FAIL sc_pixel got %h want 31", bus.core_pixel); end
        checks++; if (bus.core_start !== 1'b1) begin errors++; $display("FAIL sc_start got %0b want 1", bus.core_start); end
        checks++; if (bus.pixel_count !== 32'd1) begin errors++; $display("FAIL sc_count got %0d want 1", bus.pixel_count); end
        tick();
        checks++; if (bus.pixel_count !== 32'd2) begin errors++; $display("FAIL sc_count2 got %0d want 2", bus.pixel_count); end
        send_byte(8'h32); tick();
        send_byte(8'h33); tick();
        checks++; if (bus.pixel_count !== 32'd4) begin errors++; $display("FAIL sc_count4 got %0d want 4", bus.pixel_count); end
        checks++; if (bus.fpga_can_receive !== 1'b0) begin errors++; $display("FAIL sc_rts_drain got %0b want 0", bus.fpga_can_receive); end
        finish_frame(8'h01);
    endtask

    task automatic test_watchdog();
        int n;
        do_reset();
        bus.core_ready = 1'b1;
        send_byte(8'h40);
        tick();
        send_byte(8'h41);
        n = 0;
        while (bus.core_flush !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++; if (n !== 17) begin errors++; $display("FAIL wd_latency got %0d cycles want 17", n); end
        checks++; if (bus.err !== 2'b10) begin errors++; $display("FAIL wd_err got %b want 10", bus.err); end
        checks++; if (bus.pixel_count !== 32'd0) begin errors++; $display("FAIL wd_count got %0d want 0", bus.pixel_count); end
        checks++; if (bus.frame_active !== 1'b0) begin errors++; $display("FAIL wd_active got %0b want 0", bus.frame_active); end
        checks++; if (bus.fpga_can_receive !== 1'b1) begin errors++; $display("FAIL wd_rts got %0b want 1", bus.fpga_can_receive); end
        checks++; if (bus.core_start !== 1'b0) begin errors++; $display("FAIL wd_start got %0b want 0", bus.core_start); end
        tick();
        checks++; if (bus.core_flush !== 1'b0) begin errors++; $display("FAIL wd_flush_pulse got %0b want 0", bus.core_flush); end
        for (int i = 0; i < 4; i++) begin
            send_byte(8'(8'h50 + i));
            tick();
        end
        checks++; if (bus.pixel_count !== 32'd4) begin errors++; $display("FAIL wd_fresh_count got %0d want 4", bus.pixel_count); end
        checks++; if (bus.fpga_can_receive !== 1'b0) begin errors++; $display("FAIL wd_fresh_rts got %0b want 0", bus.fpga_can_receive); end
        finish_frame(8'h01);
        checks++; if (bus.frame_has_face !== 1'b1) begin errors++; $display("FAIL wd_fresh_face got %0b want 1", bus.frame_has_face); end
        checks++; if (bus.frame_active !== 1'b0) begin errors++; $display("FAIL wd_fresh_active got %0b want 0", bus.frame_active); end
    endtask

    task automatic test_no_face();
        bus.core_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_byte(8'(8'h60 + i));
            tick();
        end
        bus.core_return = 8'h00;
        bus.core_done   = 1'b1;
        tick();
        bus.core_done   = 1'b0;
        checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL nf_nonterminal_done got %0b want 0", bus.frame_done); end
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        checks++; if (bus.frame_active !== 1'b1) begin errors++; $display("FAIL nf_still_drain got %0b want 1", bus.frame_active); end
        checks++; if (bus.fpga_can_receive !== 1'b0) begin errors++; $display("FAIL nf_rts_drain got %0b want 0", bus.fpga_can_receive); end
        bus.core_return = 8'hFF;
        bus.core_done   = 1'b1;
        tick();
        bus.core_done   = 1'b0;
        checks++; if (bus.frame_done !== 1'b1) begin errors++; $display("FAIL nf_frame_done got %0b want 1", bus.frame_done); end
        checks++; if (bus.frame_has_face !== 1'b0) begin errors++; $display("FAIL nf_has_face got %0b want 0", bus.frame_has_face); end
        send_byte(8'h99);
        checks++; if (bus.err !== 2'b11) begin errors++; $display("FAIL nf_stray_err got %b want 11", bus.err); end
        checks++; if (bus.core_start !== 1'b0) begin errors++; $display("FAIL nf_stray_start got %0b want 0", bus.core_start); end
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        checks++; if (bus.fpga_can_receive !== 1'b1) begin errors++; $display("FAIL nf_rts_idle got %0b want 1", bus.fpga_can_receive); end
    endtask

    task automatic test_reset_mid();
        bus.core_ready = 1'b1;
        send_byte(8'h70); tick();
        send_byte(8'h71); tick();
        bus.core_ready = 1'b0;
        send_byte(8'h72);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus.core_start !== 1'b0) begin errors++; $display("FAIL rm_start got %0b want 0", bus.core_start); end
        checks++; if (bus.core_pixel !== 8'h00) begin errors++; $display("FAIL rm_pixel got %h want 00", bus.core_pixel); end
        checks++; if (bus.pixel_count !== 32'd0) begin errors++; $display("FAIL rm_count got %0d want 0", bus.pixel_count); end
        checks++; if (bus.frame_active !== 1'b0) begin errors++; $display("FAIL rm_active got %0b want 0", bus.frame_active); end
        checks++; if (bus.fpga_can_receive !== 1'b1) begin errors++; $display("FAIL rm_rts got %0b want 1", bus.fpga_can_receive); end
        checks++; if (bus.err !== 2'b00) begin errors++; $display("FAIL rm_err got %b want 00", bus.err); end
        checks++; if (bus.core_flush !== 1'b0) begin errors++; $display("FAIL rm_flush got %0b want 0", bus.core_flush); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b0;
        bus.rx_data     = 8'h00;
        bus.rx_rdy      = 1'b0;
        bus.core_ready  = 1'b0;
        bus.core_done   = 1'b0;
        bus.core_return = 8'h00;
        bus.tx_done     = 1'b0;
        test_reset();
        test_normal();
        test_back_pressure();
        test_same_cycle();
        test_watchdog();
        test_no_face();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1, "bench stalled");
    end
endmodule
`default_nettype wire
